// File: rtl/pwm_multiphase_dt.sv
// N-channel phase-shifted PWM with complementary dead-time-protected gate drives.
// One shared period counter; config is double-buffered and swapped in at the period wrap.
module pwm_multiphase_dt #(
  parameter int N_CH      = 2,
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [CNT_WIDTH-1:0]      period,
  input  logic [N_CH*CNT_WIDTH-1:0] duty,
  input  logic [N_CH*CNT_WIDTH-1:0] phase,
  input  logic [DT_WIDTH-1:0]       dead_time,
  output logic [N_CH-1:0]           ctrl_hi,
  output logic [N_CH-1:0]           ctrl_lo,
  output logic                      cycle_start,
  output logic                      busy
);

  typedef enum logic [1:0] {ST_OFF, ST_LO, ST_HI, ST_DT} ch_state_t;

  logic [CNT_WIDTH-1:0]      period_p_reg, period_a_reg;
  logic [N_CH*CNT_WIDTH-1:0] duty_p_reg, duty_a_reg;
  logic [N_CH*CNT_WIDTH-1:0] phase_p_reg, phase_a_reg;
  logic [DT_WIDTH-1:0]       dt_p_reg, dt_a_reg;
  logic                      busy_reg;
  logic [CNT_WIDTH-1:0]      cnt_reg;
  logic                      cycle_start_reg;

  logic [CNT_WIDTH-1:0]      eff_period;
  logic                      wrap;
  logic                      apply_cfg;
  logic                      dt_zero;

  assign eff_period = (period_a_reg < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period_a_reg;
  assign wrap       = en && (cnt_reg >= eff_period - CNT_WIDTH'(1));
  // A fresh load in the wrap cycle takes priority and waits for the following wrap.
  assign apply_cfg  = busy_reg && !load && (wrap || !en);
  assign dt_zero    = (dt_a_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_p_reg <= '0;
      duty_p_reg   <= '0;
      phase_p_reg  <= '0;
      dt_p_reg     <= '0;
      period_a_reg <= '0;
      duty_a_reg   <= '0;
      phase_a_reg  <= '0;
      dt_a_reg     <= '0;
      busy_reg     <= 1'b0;
    end else if (load) begin
      period_p_reg <= period;
      duty_p_reg   <= duty;
      phase_p_reg  <= phase;
      dt_p_reg     <= dead_time;
      busy_reg     <= 1'b1;
    end else if (apply_cfg) begin
      period_a_reg <= period_p_reg;
      duty_a_reg   <= duty_p_reg;
      phase_a_reg  <= phase_p_reg;
      dt_a_reg     <= dt_p_reg;
      busy_reg     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      cycle_start_reg <= 1'b0;
    end else begin
      cycle_start_reg <= en && (cnt_reg == '0);
      if (!en || wrap) cnt_reg <= '0;
      else             cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign cycle_start = cycle_start_reg;
  assign busy        = busy_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_WIDTH-1:0] duty_k, phase_k, phase_eff;
    logic [CNT_WIDTH:0]   sum, loc;
    logic                 raw, dt_done;
    ch_state_t            state_reg, state_next;
    logic                 target_reg, target_next;
    logic [DT_WIDTH-1:0]  dt_cnt_reg, dt_cnt_next;
    logic                 hi_reg, lo_reg;

    assign duty_k    = duty_a_reg[gi*CNT_WIDTH +: CNT_WIDTH];
    assign phase_k   = phase_a_reg[gi*CNT_WIDTH +: CNT_WIDTH];
    assign phase_eff = (phase_k >= eff_period) ? '0 : phase_k;
    assign sum       = {1'b0, cnt_reg} + {1'b0, phase_eff};
    assign loc       = (sum >= {1'b0, eff_period}) ? sum - {1'b0, eff_period} : sum;
    assign raw       = loc < {1'b0, duty_k};
    // Written as >= so a dead time shrunk while counting still terminates.
    assign dt_done   = ({1'b0, dt_cnt_reg} + (DT_WIDTH+1)'(1)) >= {1'b0, dt_a_reg};

    always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      dt_cnt_next = dt_cnt_reg;
      if (!en) begin
        state_next = ST_OFF;
      end else begin
        case (state_reg)
          ST_OFF: begin
            target_next = raw;
            dt_cnt_next = '0;
            state_next  = dt_zero ? (raw ? ST_HI : ST_LO) : ST_DT;
          end
          ST_LO: if (raw) begin
            target_next = 1'b1;
            dt_cnt_next = '0;
            state_next  = dt_zero ? ST_HI : ST_DT;
          end
          ST_HI: if (!raw) begin
            target_next = 1'b0;
            dt_cnt_next = '0;
            state_next  = dt_zero ? ST_LO : ST_DT;
          end
          ST_DT: begin
            if (raw != target_reg) begin
              target_next = raw;
              dt_cnt_next = '0;
            end else if (dt_done) begin
              state_next = target_reg ? ST_HI : ST_LO;
            end else begin
              dt_cnt_next = dt_cnt_reg + DT_WIDTH'(1);
            end
          end
          default: state_next = ST_OFF;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg  <= ST_OFF;
        target_reg <= 1'b0;
        dt_cnt_reg <= '0;
        hi_reg     <= 1'b0;
        lo_reg     <= 1'b0;
      end else begin
        state_reg  <= state_next;
        target_reg <= target_next;
        dt_cnt_reg <= dt_cnt_next;
        hi_reg     <= (state_next == ST_HI);
        lo_reg     <= (state_next == ST_LO);
      end
    end

    assign ctrl_hi[gi] = hi_reg;
    assign ctrl_lo[gi] = lo_reg;
  end

endmodule

// File: tb/tb_pwm_multiphase_dt.sv
// Bench for pwm_multiphase_dt: steady-state vector table with a scoreboard queue,
// plus hand-written sequences for latency, shadow loading and asynchronous reset.
module tb_pwm_multiphase_dt;
  localparam int N_CH = 2;
  localparam int CW   = 16;
  localparam int DW   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [CW-1:0]    period = '0;
  logic [N_CH*CW-1:0] duty = '0;
  logic [N_CH*CW-1:0] phase = '0;
  logic [DW-1:0]    dead_time = '0;
  logic [N_CH-1:0]  ctrl_hi, ctrl_lo;
  logic             cycle_start, busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int p, d0, ph0, d1, ph1, dt;
    int e_hi0, e_lo0, e_hi1, e_lo1;
    int win, lag;
    bit chk_lag;
  } vec_t;

  typedef struct {
    int hi0, lo0, hi1, lo1, win, lag;
    bit chk_lag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  pwm_multiphase_dt #(.N_CH(N_CH), .CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .period(period), .duty(duty), .phase(phase), .dead_time(dead_time),
    .ctrl_hi(ctrl_hi), .ctrl_lo(ctrl_lo), .cycle_start(cycle_start), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", name, act, exp_v);
    end
  endtask

  task automatic set_cfg(input int p, input int d0, input int ph0,
                         input int d1, input int ph1, input int dt);
    period    = CW'(p);
    duty      = {CW'(d1), CW'(d0)};
    phase     = {CW'(ph1), CW'(ph0)};
    dead_time = DW'(dt);
  endtask

  // Stop, load while idle, and let the pending config reach the active set.
  task automatic load_idle(input string tag, input int p, input int d0, input int ph0,
                           input int d1, input int ph1, input int dt);
    en = 1'b0;
    tick();
    set_cfg(p, d0, ph0, d1, ph1, dt);
    load = 1'b1;
    tick();
    load = 1'b0;
    check({tag, "_busy_set"}, int'(busy), 1);
    tick();
    tick();
    check({tag, "_busy_clr"}, int'(busy), 0);
  endtask

  task automatic count_hi0(output int c);
    c = 0;
    repeat (10) begin
      c += int'(ctrl_hi[0]);
      tick();
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    bit h0[64], l0[64], h1[64], l1[64], cs[64];
    int c_hi0, c_lo0, c_hi1, c_lo1, c_cs, c_ovl, c_lag;
    string tag;
    tag = $sformatf("v%0d", idx);
    load_idle(tag, v.p, v.d0, v.ph0, v.d1, v.ph1, v.dt);
    sb.push_back('{v.e_hi0, v.e_lo0, v.e_hi1, v.e_lo1, v.win, v.lag, v.chk_lag});
    en = 1'b1;
    repeat (4 * v.win + 20) tick();
    for (int i = 0; i < 2 * v.win; i++) begin
      h0[i] = ctrl_hi[0];
      l0[i] = ctrl_lo[0];
      h1[i] = ctrl_hi[1];
      l1[i] = ctrl_lo[1];
      cs[i] = cycle_start;
      tick();
    end
    e = sb.pop_front();
    c_hi0 = 0; c_lo0 = 0; c_hi1 = 0; c_lo1 = 0; c_cs = 0; c_ovl = 0; c_lag = 0;
    for (int i = 0; i < e.win; i++) begin
      c_hi0 += int'(h0[i]);
      c_lo0 += int'(l0[i]);
      c_hi1 += int'(h1[i]);
      c_lo1 += int'(l1[i]);
      c_cs  += int'(cs[i]);
      if (h1[i + e.lag] != h0[i]) c_lag++;
    end
    for (int i = 0; i < 2 * e.win; i++)
      if ((h0[i] && l0[i]) || (h1[i] && l1[i])) c_ovl++;
    $display("vec %0d: period=%0d dt=%0d hi0=%0d lo0=%0d hi1=%0d lo1=%0d starts=%0d",
             idx, v.p, v.dt, c_hi0, c_lo0, c_hi1, c_lo1, c_cs);
    check({tag, "_hi0_width"}, c_hi0, e.hi0);
    check({tag, "_lo0_width"}, c_lo0, e.lo0);
    check({tag, "_hi1_width"}, c_hi1, e.hi1);
    check({tag, "_lo1_width"}, c_lo1, e.lo1);
    check({tag, "_cycle_starts"}, c_cs, 1);
    check({tag, "_overlap"}, c_ovl, 0);
    if (e.chk_lag) check({tag, "_phase_shift"}, c_lag, 0);
  endtask

  initial begin
    int c;
    int found;
    // p d0 ph0 d1 ph1 dt | hi0 lo0 hi1 lo1 | win lag chk
    vecs[0] = '{10,  5, 0, 5,  5, 0,  5,  5, 5,  5, 10, 5, 1'b1};
    vecs[1] = '{10,  5, 0, 5,  5, 2,  3,  3, 3,  3, 10, 5, 1'b1};
    vecs[2] = '{10,  5, 0, 5, 12, 0,  5,  5, 5,  5, 10, 0, 1'b1};
    vecs[3] = '{10,  5, 0, 5,  3, 0,  5,  5, 5,  5, 10, 7, 1'b1};
    vecs[4] = '{10, 12, 0, 0,  0, 0, 10,  0, 0, 10, 10, 0, 1'b0};
    vecs[5] = '{10,  1, 0, 3,  0, 2,  0,  7, 1,  5, 10, 0, 1'b0};
    vecs[6] = '{ 7,  3, 0, 4,  2, 1,  2,  3, 3,  2,  7, 0, 1'b0};
    vecs[7] = '{ 1,  1, 0, 0,  0, 0,  1,  1, 0,  2,  2, 0, 1'b0};
    vecs[8] = '{10,  5, 0, 5,  0, 6,  0,  0, 0,  0, 10, 0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl_hi", int'(ctrl_hi), 0);
    check("rst_ctrl_lo", int'(ctrl_lo), 0);
    check("rst_cycle_start", int'(cycle_start), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // First-edge latency and cycle_start spacing
    load_idle("lat", 10, 5, 0, 5, 5, 0);
    en = 1'b1;
    check("lat_hi0_before", int'(ctrl_hi[0]), 0);
    tick();
    check("lat_hi0_first", int'(ctrl_hi[0]), 1);
    check("lat_lo0_first", int'(ctrl_lo[0]), 0);
    check("lat_cs_first", int'(cycle_start), 1);
    repeat (4) tick();
    check("lat_hi0_last", int'(ctrl_hi[0]), 1);
    tick();
    check("lat_hi0_fall", int'(ctrl_hi[0]), 0);
    check("lat_lo0_rise", int'(ctrl_lo[0]), 1);
    repeat (4) tick();
    check("lat_cs_gap", int'(cycle_start), 0);
    tick();
    check("lat_cs_second", int'(cycle_start), 1);
    $display("seq latency done");

    // Mid-period load at cnt=3
    repeat (2) tick();
    set_cfg(10, 8, 0, 5, 5, 0);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("mid_busy_pending", int'(busy), 1);
    c = 0;
    for (int i = 0; i < 30; i++) begin
      if (cycle_start) break;
      c += int'(ctrl_hi[0]);
      tick();
    end
    check("mid_wrap_seen", int'(cycle_start), 1);
    check("mid_busy_after_wrap", int'(busy), 0);
    check("mid_old_duty_tail", c, 2);
    count_hi0(c);
    check("mid_new_duty", c, 8);
    $display("seq mid-period load done");

    // Load sampled in the wrap cycle applies one period later
    repeat (8) tick();
    set_cfg(10, 2, 0, 5, 5, 0);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("wrapld_busy_cnt0", int'(busy), 1);
    tick();
    check("wrapld_cs", int'(cycle_start), 1);
    check("wrapld_busy_cs", int'(busy), 1);
    count_hi0(c);
    check("wrapld_old_duty", c, 8);
    check("wrapld_busy_clr", int'(busy), 0);
    count_hi0(c);
    check("wrapld_new_duty", c, 2);
    $display("seq wrap-cycle load done");

    // Asynchronous reset during ch0 dead time
    load_idle("ar", 10, 5, 0, 5, 3, 2);
    en = 1'b1;
    repeat (30) tick();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ctrl_hi[0] && !ctrl_lo[0]) begin
        found = 1;
        break;
      end
      tick();
    end
    check("ar_dt_found", found, 1);
    check("ar_ch1_on", int'(ctrl_hi[1] | ctrl_lo[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ctrl_hi_async", int'(ctrl_hi), 0);
    check("ar_ctrl_lo_async", int'(ctrl_lo), 0);
    check("ar_busy_async", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) tick();
    begin
      int c_hi0, c_lo0, c_lo1;
      c_hi0 = 0; c_lo0 = 0; c_lo1 = 0;
      repeat (6) begin
        c_hi0 += int'(ctrl_hi[0]);
        c_lo0 += int'(ctrl_lo[0]);
        c_lo1 += int'(ctrl_lo[1]);
        tick();
      end
      check("ar_post_hi0", c_hi0, 0);
      check("ar_post_lo0", c_lo0, 6);
      check("ar_post_lo1", c_lo1, 6);
    end
    $display("seq async reset done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/pwm_multiphase_dt.md
Name: pwm_multiphase_dt

Overview:
Synthesizable N-channel phase-shifted PWM generator with complementary, dead-time-protected gate-drive outputs. It is the parametrised successor to the fixed single-channel, fixed-duty PWM gate-drive macro. It drives the ctrl inputs of emulated switching converters (multiphase buck, half/full bridges). All channels share one period counter. Per-channel duty and phase, plus shared period and dead time, are runtime-programmable through glitch-free shadow registers.

Parameters:
N_CH, 2, number of channels
CNT_WIDTH, 16, width of period/duty/phase values and counter
DT_WIDTH, 8, width of dead-time value

Ports:
clk  in  1  emulator clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable
load  in  1  single-cycle strobe: capture cfg inputs into pending registers
period  in  CNT_WIDTH  PWM period in clk cycles
duty  in  N_CH*CNT_WIDTH  per-channel high-side on-count, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
phase  in  N_CH*CNT_WIDTH  per-channel counter offset, same packing
dead_time  in  DT_WIDTH  both-off interval in clk cycles
ctrl_hi  out  N_CH  high-side gate drive
ctrl_lo  out  N_CH  low-side gate drive
cycle_start  out  1  one-cycle pulse at each period start
busy  out  1  load pending, not yet applied

Behaviour:
- Reset (async, rst_n=0): counter=0; active and pending cfg cleared; ctrl_hi=0, ctrl_lo=0, cycle_start=0, busy=0; all channel FSMs go to OFF. All outputs are registered.
- Config path:
  - load=1 copies period/duty/phase/dead_time into pending registers and sets busy.
  - Pending is copied into active cfg on the clock where the counter wraps (period_a-1 -> 0); busy clears on the same clock.
  - A load sampled in the wrap cycle itself applies at the following wrap.
  - Repeated loads overwrite pending (last wins).
  - While en=0, a load applies on the next clock.
- Effective period: max(period_a, 2).
- Phase rule: phase_a[k] >= effective period is treated as 0.
- Counter:
  - en=0: counter held at 0.
  - en=1: counter increments and wraps to 0 after effective period-1.
  - cycle_start(t+1) = en(t) && cnt(t)==0.
- Channel compare: loc_k = cnt+phase_k, minus period if the sum >= period (computed at CNT_WIDTH+1 bits). raw_k = (loc_k < duty_k). duty_k=0 gives raw constantly 0; duty_k >= period gives raw constantly 1.
- Channel FSM, per channel, states OFF/LO/HI/DT with a target bit and dt_cnt:
  - OFF: hi=0, lo=0. If en=1, go to DT with target=raw and dt_cnt=0; if dead_time=0, go directly to HI or LO.
  - LO (lo=1): if raw=1, go to DT with target=1, or directly to HI when dead_time=0.
  - HI (hi=1): if raw=0, go to DT with target=0, or directly to LO when dead_time=0.
  - DT (both 0): if raw != target, set target=raw and dt_cnt=0. Otherwise dt_cnt++; on reaching dead_time-1, enter the target state next clock. Both outputs are therefore off for exactly dead_time cycles after the last raw edge.
  - en=0 in any state: OFF on the next clock.
  - hi and lo are never both 1.
- Latency: with dead_time=0, hi_k(t+1)=raw_k(t). With dead_time=d>0, each turn-on edge is delayed by an extra d cycles and turn-off edges are not delayed. Steady state: hi width = duty-d, lo width = period-duty-d; a width <= 0 means that side never turns on.
- Reset mid-operation: outputs clear immediately (async). On release, the block restarts from counter 0 using the reset cfg (all zero), so a load is required before the outputs become meaningful.

Test Plan:
- period=10, duty0=5, phase0=0, dt=0, load then en=1 -> hi0 repeats 5 high/5 low; lo0 is the exact complement; cycle_start every 10 clocks; first hi0 high 1 clock after the counter starts.
- Same setup with dt=2 -> hi0 3 high, 2 both-off, lo0 3 high, 2 both-off, repeating; hi0&lo0 never both 1.
- N_CH=2, period=10, duty=5/5, phase=0/5 -> hi1 equals hi0 shifted by 5 clocks (antiphase); phase1=12 -> behaves as phase 0.
- Mid-period load of duty0=8 at cnt=3 -> current period keeps duty 5, busy=1 until the wrap, next period hi0 8 high; a load in the wrap cycle applies one period later.
- duty0=12 (>= period) -> hi0 constantly 1 after the first DT; duty0=0 -> lo0 constantly 1; duty0=1 with dt=2 -> hi0 never asserts, lo0 low for 3 clocks per period.
- Assert rst_n=0 asynchronously mid-DT -> all outputs 0 without waiting for a clk edge; after release with en=1 and no load -> hi0=0, lo0=1 steady (all-zero cfg).
